spdif_channel_status_decoder: RTL and testbench
===============================================

# spdif_channel_status_decoder

Receive-side counterpart of the consumer channel-status layout. Collects one channel-status bit per received channel-A subframe, frames 192-bit blocks on the "B" block-start indication, and confirms the word over several identical consecutive blocks. Publishes the confirmed 192-bit word and its decoded mode-0 consumer fields. Sits after the S/PDIF biphase/preamble decoder and before the audio format/clock-recovery logic.

## Interface
- CONFIRM_BLOCKS, 2: consecutive identical complete blocks required before the word is published (range 1..15).
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rxLocked  in  1  upstream decoder locked; low forces resynchronisation.
- subframeValid  in  1  one-cycle strobe: a subframe was received this cycle.
- subframeChannel  in  1  0 = channel A (B/M preamble), 1 = channel B (W preamble).
- blockStart  in  1  qualified by subframeValid; subframe carried a "B" preamble.
- csBit  in  1  channel-status bit of this subframe.
- channelStatus  out  192  confirmed word; bit i is from the i-th frame after the block start (bit 0 = block-start frame).
- professional  out  1  channelStatus[0].
- nonPcm  out  1  channelStatus[1].
- copyrightFree  out  1  channelStatus[2] (1 = copyright not asserted).
- categoryCode  out  8  channelStatus[15:8].
- channelNum  out  4  channelStatus[23:20].
- samplingFreq  out  4  channelStatus[27:24].
- wordLength  out  4  channelStatus[35:32].
- statusValid  out  1  a confirmed word is present.
- statusChanged  out  1  one-cycle pulse when the published word is loaded with a different value.
- blockError  out  1  one-cycle pulse on a framing error.

## Operation
- Only strobes with subframeValid=1 and subframeChannel=0 are processed; channel-B subframes are ignored entirely, including any blockStart.
- States: HUNT, COLLECT.
- HUNT: wait for an A subframe with blockStart. Store csBit at index 0, set bitCount=1, go to COLLECT.
- COLLECT, A subframe without blockStart:
  - bitCount<192: store csBit at index bitCount; increment bitCount.
  - bitCount==192 (missing B): pulse blockError, clear matchCount and statusValid, go to HUNT.
- COLLECT, A subframe with blockStart:
  - bitCount==192 (block complete): compare the collected word with candidate.
    - Equal: matchCount saturates at CONFIRM_BLOCKS.
    - Different: candidate = collected word, matchCount = 1.
    - If the resulting matchCount==CONFIRM_BLOCKS: load channelStatus from candidate and set statusValid. Pulse statusChanged only if the loaded value differs from the previous channelStatus, or if statusValid was 0.
  - bitCount!=192 (early B): pulse blockError, clear matchCount and statusValid. Still process the frame as bit 0 of a new block.
  - In both cases: store csBit at index 0, set bitCount=1, remain in COLLECT.
- rxLocked=0 in any cycle: go to HUNT, clear bitCount, matchCount and statusValid. Any strobe in that cycle is dropped, and no blockError is raised.
- Clearing statusValid does not clear channelStatus. The fields hold the last confirmed word.
- Field outputs are pure slices of the registered channelStatus.

## Timing
- All outputs are registered. Reset values: channelStatus=0, all fields 0, statusValid=0, statusChanged=0, blockError=0. State after reset is HUNT, with bitCount=0, matchCount=0 and candidate=0.
- Latency: the confirming block-start strobe is in cycle N. channelStatus, statusValid and statusChanged update in cycle N+1. blockError asserts in cycle N+1 after the offending strobe.
- Strobes may arrive on consecutive cycles; one strobe is fully processed per cycle.
- Reset asserted mid-block discards the partial block; the module restarts in HUNT.
- bitCount is 8 bits and never exceeds 192.
- matchCount is 4 bits.

## Structure
- Shared package spdif_cs_pkg holds the channel-status field bit positions and widths as localparams: CS_PRO, CS_NONPCM, CS_COPY, CS_CAT_LSB, CS_CHNUM_LSB, CS_FS_LSB, CS_WLEN_LSB, and CS_BLOCK_BITS=192. The existing encoder and this decoder both use it.
- One natural sub-module, spdif_cs_field_extract: combinational slicing of a 192-bit word into the field outputs. It can be reused by HDMI audio-packet paths.

## Test plan
- Three identical blocks with categoryCode=8'b10011001, samplingFreq=2, wordLength=2, channelNum=1, CONFIRM_BLOCKS=2 -> statusValid and statusChanged rise one cycle after the block-start of block 3. The fields read 0x99/2/2/1.
- Block 1 word X, then blocks 2 and 3 word Y -> X is never published; Y is published after block 3's completing B.
- B arrives after 150 A frames -> blockError pulses once and statusValid=0. The next two clean blocks republish the word, with statusChanged=1.
- 193rd A frame without B -> blockError pulses and the state goes to HUNT. The bits before the next B are ignored.
- Channel-B subframes interleaved with blockStart=1 and inverted csBit -> published word is unaffected.
- rxLocked dropped mid-block, then reset asserted mid-block -> statusValid=0 with no blockError; all outputs read 0 after reset. Recovery takes CONFIRM_BLOCKS full blocks after the first B.

Source files
------------

// File: rtl/spdif_cs_pkg.sv
// Channel-status field positions for the consumer (mode-0) layout.
// The S/PDIF encoder and decoder both use this package.
package spdif_cs_pkg;

    localparam int CS_BLOCK_BITS = 192;

    localparam int CS_PRO        = 0;
    localparam int CS_NONPCM     = 1;
    localparam int CS_COPY       = 2;
    localparam int CS_CAT_LSB    = 8;
    localparam int CS_CAT_BITS   = 8;
    localparam int CS_CHNUM_LSB  = 20;
    localparam int CS_CHNUM_BITS = 4;
    localparam int CS_FS_LSB     = 24;
    localparam int CS_FS_BITS    = 4;
    localparam int CS_WLEN_LSB   = 32;
    localparam int CS_WLEN_BITS  = 4;

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } cs_state_t;

endpackage

// File: rtl/spdif_channel_status_decoder_if.sv
// Subframe strobe bus from the biphase/preamble decoder to the
// channel-status decoder.
interface spdif_channel_status_decoder_if;
    logic rxLocked;
    logic subframeValid;
    logic subframeChannel;
    logic blockStart;
    logic csBit;

    modport master (
        output rxLocked, subframeValid, subframeChannel, blockStart, csBit
    );

    modport slave (
        input rxLocked, subframeValid, subframeChannel, blockStart, csBit
    );
endinterface

// File: rtl/spdif_cs_field_extract.sv
// Pure combinational slicing of a 192-bit channel-status word into its
// mode-0 consumer fields.
module spdif_cs_field_extract
    import spdif_cs_pkg::*;
(
    input  logic [CS_BLOCK_BITS-1:0] word,
    output logic                     professional,
    output logic                     nonPcm,
    output logic                     copyrightFree,
    output logic [CS_CAT_BITS-1:0]   categoryCode,
    output logic [CS_CHNUM_BITS-1:0] channelNum,
    output logic [CS_FS_BITS-1:0]    samplingFreq,
    output logic [CS_WLEN_BITS-1:0]  wordLength
);

    assign professional  = word[CS_PRO];
    assign nonPcm        = word[CS_NONPCM];
    assign copyrightFree = word[CS_COPY];
    assign categoryCode  = word[CS_CAT_LSB +: CS_CAT_BITS];
    assign channelNum    = word[CS_CHNUM_LSB +: CS_CHNUM_BITS];
    assign samplingFreq  = word[CS_FS_LSB +: CS_FS_BITS];
    assign wordLength    = word[CS_WLEN_LSB +: CS_WLEN_BITS];

endmodule

// File: rtl/spdif_channel_status_decoder.sv
// Frames channel-A channel-status bits into 192-bit blocks and publishes the
// word once CONFIRM_BLOCKS consecutive identical blocks have been seen.
module spdif_channel_status_decoder
    import spdif_cs_pkg::*;
#(
    parameter int CONFIRM_BLOCKS = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    spdif_channel_status_decoder_if.slave rx,
    output logic [CS_BLOCK_BITS-1:0]    channelStatus,
    output logic                        professional,
    output logic                        nonPcm,
    output logic                        copyrightFree,
    output logic [CS_CAT_BITS-1:0]      categoryCode,
    output logic [CS_CHNUM_BITS-1:0]    channelNum,
    output logic [CS_FS_BITS-1:0]       samplingFreq,
    output logic [CS_WLEN_BITS-1:0]     wordLength,
    output logic                        statusValid,
    output logic                        statusChanged,
    output logic                        blockError
);

    localparam logic [3:0] CONFIRM   = 4'(CONFIRM_BLOCKS);
    localparam logic [7:0] FULL_BITS = 8'(CS_BLOCK_BITS);

    cs_state_t                state;
    logic [7:0]               bitCount;
    logic [3:0]               matchCount;
    logic [CS_BLOCK_BITS-1:0] collected;
    logic [CS_BLOCK_BITS-1:0] candidate;
    logic [3:0]               nextMatch;
    logic                     aStrobe;

    assign aStrobe = rx.subframeValid && !rx.subframeChannel;

    // Confirmation count that a completed block would produce.
    always_comb begin
        nextMatch = 4'd1;
        if (collected == candidate) begin
            nextMatch = (matchCount >= CONFIRM) ? CONFIRM : matchCount + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= HUNT;
            bitCount      <= '0;
            matchCount    <= '0;
            collected     <= '0;
            candidate     <= '0;
            channelStatus <= '0;
            statusValid   <= 1'b0;
            statusChanged <= 1'b0;
            blockError    <= 1'b0;
        end else begin
            statusChanged <= 1'b0;
            blockError    <= 1'b0;
            if (!rx.rxLocked) begin
                state       <= HUNT;
                bitCount    <= '0;
                matchCount  <= '0;
                statusValid <= 1'b0;
            end else if (aStrobe) begin
                case (state)
                    HUNT: begin
                        if (rx.blockStart) begin
                            collected[0] <= rx.csBit;
                            bitCount     <= 8'd1;
                            state        <= COLLECT;
                        end
                    end
                    COLLECT: begin
                        if (!rx.blockStart) begin
                            if (bitCount < FULL_BITS) begin
                                collected[bitCount] <= rx.csBit;
                                bitCount            <= bitCount + 8'd1;
                            end else begin
                                blockError  <= 1'b1;
                                matchCount  <= '0;
                                statusValid <= 1'b0;
                                bitCount    <= '0;
                                state       <= HUNT;
                            end
                        end else begin
                            if (bitCount == FULL_BITS) begin
                                matchCount <= nextMatch;
                                if (collected != candidate) begin
                                    candidate <= collected;
                                end
                                if (nextMatch == CONFIRM) begin
                                    channelStatus <= collected;
                                    statusValid   <= 1'b1;
                                    statusChanged <= (collected != channelStatus) || !statusValid;
                                end
                            end else begin
                                blockError  <= 1'b1;
                                matchCount  <= '0;
                                statusValid <= 1'b0;
                            end
                            collected[0] <= rx.csBit;
                            bitCount     <= 8'd1;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    spdif_cs_field_extract fields (
        .word          (channelStatus),
        .professional  (professional),
        .nonPcm        (nonPcm),
        .copyrightFree (copyrightFree),
        .categoryCode  (categoryCode),
        .channelNum    (channelNum),
        .samplingFreq  (samplingFreq),
        .wordLength    (wordLength)
    );

endmodule

// File: tb/tb_spdif_channel_status_decoder.sv
// Directed bench for the channel-status decoder: confirmation, framing
// errors, channel-B rejection, lock loss and reset recovery.
module tb_spdif_channel_status_decoder;

    logic         clk = 1'b0;
    logic         reset;
    logic [191:0] channelStatus;
    logic         professional, nonPcm, copyrightFree;
    logic [7:0]   categoryCode;
    logic [3:0]   channelNum, samplingFreq, wordLength;
    logic         statusValid, statusChanged, blockError;

    int compared   = 0;
    int mismatched = 0;

    logic [191:0] wordA, wordX, wordY, wordZ;

    spdif_channel_status_decoder_if bus ();

    spdif_channel_status_decoder #(.CONFIRM_BLOCKS(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .rx            (bus),
        .channelStatus (channelStatus),
        .professional  (professional),
        .nonPcm        (nonPcm),
        .copyrightFree (copyrightFree),
        .categoryCode  (categoryCode),
        .channelNum    (channelNum),
        .samplingFreq  (samplingFreq),
        .wordLength    (wordLength),
        .statusValid   (statusValid),
        .statusChanged (statusChanged),
        .blockError    (blockError)
    );

    always #5 clk = ~clk;

    function automatic logic [191:0] makeWord(input logic pro, input logic npcm,
            input logic copy, input logic [7:0] cat, input logic [3:0] ch,
            input logic [3:0] fs, input logic [3:0] wl, input logic [11:0] tail);
        logic [191:0] w;
        w          = '0;
        w[0]       = pro;
        w[1]       = npcm;
        w[2]       = copy;
        w[15:8]    = cat;
        w[23:20]   = ch;
        w[27:24]   = fs;
        w[35:32]   = wl;
        w[191:180] = tail;
        return w;
    endfunction

    task automatic checkOutput(input string tag, input logic [191:0] observed,
                               input logic [191:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // One A or B subframe strobe, driven for exactly one clock.
    task automatic applyStimulus(input logic chan, input logic start, input logic cs);
        @(negedge clk);
        bus.subframeValid   = 1'b1;
        bus.subframeChannel = chan;
        bus.blockStart      = start;
        bus.csBit           = cs;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.subframeValid = 1'b0;
        bus.blockStart    = 1'b0;
    endtask

    task automatic sendRange(input logic [191:0] w, input int lo, input int hi,
                             input bit interleave);
        for (int i = lo; i <= hi; i++) begin
            applyStimulus(1'b0, i == 0, w[i]);
            if (interleave) applyStimulus(1'b1, 1'b1, ~w[i]);
        end
    endtask

    initial begin
        wordA = makeWord(1'b0, 1'b0, 1'b1, 8'b10011001, 4'd1, 4'd2, 4'd2, 12'hA5C);
        wordX = makeWord(1'b0, 1'b0, 1'b0, 8'h55, 4'd3, 4'd1, 4'd9, 12'h0F1);
        wordY = makeWord(1'b1, 1'b0, 1'b1, 8'h01, 4'd2, 4'd3, 4'hB, 12'h813);
        wordZ = makeWord(1'b0, 1'b1, 1'b0, 8'h20, 4'h8, 4'hC, 4'h4, 12'hFFF);

        reset               = 1'b1;
        bus.rxLocked        = 1'b1;
        bus.subframeValid   = 1'b0;
        bus.subframeChannel = 1'b0;
        bus.blockStart      = 1'b0;
        bus.csBit           = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_cs", channelStatus, 192'h0);
        checkOutput("reset_valid", 192'(statusValid), 192'(1'b0));
        checkOutput("reset_changed", 192'(statusChanged), 192'(1'b0));
        checkOutput("reset_err", 192'(blockError), 192'(1'b0));
        checkOutput("reset_cat", 192'(categoryCode), 192'(8'h00));
        reset = 1'b0;

        $display("[TB] three identical blocks");
        sendRange(wordA, 0, 191, 1'b0);
        sendRange(wordA, 0, 0, 1'b0);
        idle();
        checkOutput("blk2_not_valid", 192'(statusValid), 192'(1'b0));
        sendRange(wordA, 1, 191, 1'b0);
        sendRange(wordA, 0, 0, 1'b0);
        idle();
        checkOutput("blk3_valid", 192'(statusValid), 192'(1'b1));
        checkOutput("blk3_changed", 192'(statusChanged), 192'(1'b1));
        checkOutput("blk3_word", channelStatus, wordA);
        checkOutput("blk3_cat", 192'(categoryCode), 192'(8'h99));
        checkOutput("blk3_fs", 192'(samplingFreq), 192'(4'd2));
        checkOutput("blk3_wlen", 192'(wordLength), 192'(4'd2));
        checkOutput("blk3_chnum", 192'(channelNum), 192'(4'd1));
        checkOutput("blk3_copy", 192'(copyrightFree), 192'(1'b1));
        checkOutput("blk3_pro", 192'(professional), 192'(1'b0));
        idle();
        checkOutput("changed_pulse_end", 192'(statusChanged), 192'(1'b0));

        $display("[TB] X then Y Y");
        sendRange(wordA, 1, 191, 1'b0);
        sendRange(wordX, 0, 191, 1'b0);
        sendRange(wordY, 0, 191, 1'b0);
        sendRange(wordY, 0, 0, 1'b0);
        idle();
        checkOutput("x_not_published", channelStatus, wordA);
        checkOutput("x_valid_kept", 192'(statusValid), 192'(1'b1));
        sendRange(wordY, 1, 191, 1'b0);
        sendRange(wordY, 0, 0, 1'b0);
        idle();
        checkOutput("y_published", channelStatus, wordY);
        checkOutput("y_changed", 192'(statusChanged), 192'(1'b1));
        checkOutput("y_pro", 192'(professional), 192'(1'b1));

        $display("[TB] early B after 150 frames");
        sendRange(wordY, 1, 149, 1'b0);
        sendRange(wordY, 0, 0, 1'b0);
        idle();
        checkOutput("early_err", 192'(blockError), 192'(1'b1));
        checkOutput("early_valid", 192'(statusValid), 192'(1'b0));
        checkOutput("early_hold", channelStatus, wordY);
        idle();
        checkOutput("early_err_end", 192'(blockError), 192'(1'b0));
        sendRange(wordY, 1, 191, 1'b0);
        sendRange(wordY, 0, 0, 1'b0);
        idle();
        checkOutput("early_rec1_valid", 192'(statusValid), 192'(1'b0));
        sendRange(wordY, 1, 191, 1'b0);
        sendRange(wordY, 0, 0, 1'b0);
        idle();
        checkOutput("early_rec2_valid", 192'(statusValid), 192'(1'b1));
        checkOutput("early_rec2_changed", 192'(statusChanged), 192'(1'b1));

        $display("[TB] 193rd frame without B");
        sendRange(wordY, 1, 191, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        idle();
        checkOutput("missing_b_err", 192'(blockError), 192'(1'b1));
        checkOutput("missing_b_valid", 192'(statusValid), 192'(1'b0));
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b1);
        sendRange(wordY, 0, 191, 1'b0);
        sendRange(wordY, 0, 191, 1'b0);
        sendRange(wordY, 0, 0, 1'b0);
        idle();
        checkOutput("missing_b_rec_valid", 192'(statusValid), 192'(1'b1));
        checkOutput("missing_b_rec_word", channelStatus, wordY);

        $display("[TB] channel-B interleave");
        sendRange(wordY, 1, 191, 1'b1);
        sendRange(wordZ, 0, 191, 1'b1);
        sendRange(wordZ, 0, 191, 1'b1);
        sendRange(wordZ, 0, 0, 1'b1);
        idle();
        checkOutput("chb_word", channelStatus, wordZ);
        checkOutput("chb_nonpcm", 192'(nonPcm), 192'(1'b1));
        checkOutput("chb_fs", 192'(samplingFreq), 192'(4'hC));
        checkOutput("chb_err", 192'(blockError), 192'(1'b0));

        $display("[TB] lock loss mid-block");
        sendRange(wordZ, 1, 50, 1'b0);
        @(negedge clk);
        bus.rxLocked        = 1'b0;
        bus.subframeValid   = 1'b1;
        bus.subframeChannel = 1'b0;
        bus.blockStart      = 1'b1;
        idle();
        checkOutput("unlock_valid", 192'(statusValid), 192'(1'b0));
        checkOutput("unlock_err", 192'(blockError), 192'(1'b0));
        checkOutput("unlock_hold", channelStatus, wordZ);
        idle();
        checkOutput("unlock_err2", 192'(blockError), 192'(1'b0));
        bus.rxLocked = 1'b1;
        sendRange(wordZ, 0, 191, 1'b0);
        sendRange(wordZ, 0, 0, 1'b0);
        idle();
        checkOutput("unlock_rec1_valid", 192'(statusValid), 192'(1'b0));
        sendRange(wordZ, 1, 191, 1'b0);
        sendRange(wordZ, 0, 0, 1'b0);
        idle();
        checkOutput("unlock_rec2_valid", 192'(statusValid), 192'(1'b1));
        checkOutput("unlock_rec2_changed", 192'(statusChanged), 192'(1'b1));

        $display("[TB] reset mid-block");
        sendRange(wordZ, 1, 80, 1'b0);
        idle();
        reset = 1'b1;
        #1;
        checkOutput("midrst_cs", channelStatus, 192'h0);
        checkOutput("midrst_valid", 192'(statusValid), 192'(1'b0));
        checkOutput("midrst_nonpcm", 192'(nonPcm), 192'(1'b0));
        checkOutput("midrst_fs", 192'(samplingFreq), 192'(4'h0));
        @(negedge clk);
        reset = 1'b0;
        sendRange(wordA, 0, 191, 1'b0);
        sendRange(wordA, 0, 0, 1'b0);
        idle();
        checkOutput("rst_rec1_valid", 192'(statusValid), 192'(1'b0));
        sendRange(wordA, 1, 191, 1'b0);
        sendRange(wordA, 0, 0, 1'b0);
        idle();
        checkOutput("rst_rec2_valid", 192'(statusValid), 192'(1'b1));
        checkOutput("rst_rec2_word", channelStatus, wordA);
        checkOutput("rst_rec2_changed", 192'(statusChanged), 192'(1'b1));

        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
